// File: rtl/gray_code_conv_arbiter.sv
// ============================================================================
// gray_code_conv_arbiter -- round-robin shared Binary<->Gray conversion engine
// Revision: 1.0
// ============================================================================
`default_nettype none

module gray_code_conv_arbiter #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ-1:0]           req_mode,
   input  logic [N_REQ*WIDTH-1:0]     req_data,
   output logic [N_REQ-1:0]           req_ready,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [WIDTH-1:0]           rsp_data,
   output logic [$clog2(N_REQ)-1:0]   rsp_id,
   output logic                       busy
);

   localparam int ID_W  = $clog2(N_REQ);
   localparam int IDX_W = $clog2(WIDTH);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] B2G  = 2'd1;
   localparam logic [1:0] G2B  = 2'd2;
   localparam logic [1:0] RESP = 2'd3;

   logic [1:0]       state;
   logic [1:0]       state_next;
   logic [ID_W-1:0]  ptr;
   logic [ID_W-1:0]  ptr_next;
   logic [ID_W-1:0]  sel;
   logic [ID_W-1:0]  id;
   logic             found;
   logic [WIDTH-1:0] sel_data;
   logic [WIDTH-1:0] data;
   logic [WIDTH-1:0] result;
   logic [IDX_W-1:0] idx;

   // Rotating search: first valid requester at or after ptr wins.
   always_comb begin
      int c;
      c     = 0;
      found = 1'b0;
      sel   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         c = (int'(ptr) + i) % N_REQ;
         if (!found && req_valid[ID_W'(c)]) begin
            found = 1'b1;
            sel   = ID_W'(c);
         end
      end
   end

   assign sel_data = req_data[int'(sel)*WIDTH +: WIDTH];
   assign ptr_next = (sel == ID_W'(N_REQ-1)) ? '0 : sel + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (found) state_next = req_mode[sel] ? G2B : B2G;
         B2G:     state_next = RESP;
         G2B:     if (idx == IDX_W'(1)) state_next = RESP;
         RESP:    if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Grant is gated by rst_n so no strobe escapes while reset is held.
   always_comb begin
      req_ready = '0;
      rsp_valid = (state == RESP);
      busy      = (state != IDLE);
      if (state == IDLE && found && rst_n) begin
         req_ready[sel] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr    <= '0;
         idx    <= '0;
         result <= '0;
         id     <= '0;
         data   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  ptr  <= ptr_next;
                  id   <= sel;
                  data <= sel_data;
                  if (req_mode[sel]) begin
                     result[WIDTH-1] <= sel_data[WIDTH-1];
                     idx             <= IDX_W'(WIDTH-1);
                  end
               end
            end
            B2G: result <= data ^ (data >> 1);
            G2B: begin
               // Each binary bit is the XOR of the next-higher binary bit and this Gray bit.
               result[idx-1'b1] <= result[idx] ^ data[idx-1'b1];
               idx              <= idx - 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign rsp_data = result;
   assign rsp_id   = id;

endmodule

`default_nettype wire

// File: doc/gray_code_conv_arbiter.md
# gray_code_conv_arbiter

Shares one sequential Binary↔Gray conversion engine among `N_REQ` requesters through valid/ready handshakes. Grants are round-robin.
- Binary→Gray is computed in one step.
- Gray→Binary is computed serially, one bit per clock, MSB first.
- The result is held on a single response port until it is consumed.

The block sits between the code-conversion requesters (counters, encoders, test sources) and downstream consumers. It is the controller/scheduler for the 4-bit Binary/Gray datapath.

## Interface
- `N_REQ`, default 4: number of requesters. Must be ≥ 2.
- `WIDTH`, default 4: code width in bits. Must be ≥ 2.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  N_REQ: request pending, one bit per requester.
- `req_mode`  in  N_REQ: per requester. 0 = Binary→Gray, 1 = Gray→Binary.
- `req_data`  in  N_REQ*WIDTH: requester k occupies bits [k*WIDTH +: WIDTH].
- `req_ready`  out  N_REQ: one-hot accept strobe.
- `rsp_valid`  out  1: result available.
- `rsp_ready`  in  1: consumer accepts the result.
- `rsp_data`  out  WIDTH: converted value.
- `rsp_id`  out  $clog2(N_REQ): index of the requester that owns the result.
- `busy`  out  1: high in every state except IDLE.

## Operation
- FSM states: IDLE, B2G, G2B, RESP.
- **IDLE**
  - Selects the first k with `req_valid[k]=1`, searching k = ptr, ptr+1, … mod N_REQ.
  - `req_ready[k]` is high combinationally in that same cycle. It is 1 only in IDLE and only for the selected k.
  - On that edge (the acceptance), the block latches data, mode and id, and sets ptr ← (k+1) mod N_REQ.
  - Next state is B2G if mode=0, G2B if mode=1.
  - With no valid requests it stays in IDLE and ptr is unchanged.
- **B2G**: result ← d ^ (d >> 1), then go to RESP.
- **G2B**
  - At acceptance: result[WIDTH-1] ← g[WIDTH-1] and idx ← WIDTH-1.
  - Each cycle: result[idx-1] ← result[idx] ^ g[idx-1], then idx ← idx-1.
  - When idx reaches 1 the final bit is written and the FSM goes to RESP.
- **RESP**
  - `rsp_valid`=1. `rsp_data` and `rsp_id` stay stable until `rsp_ready`=1.
  - On the handshake edge the FSM returns to IDLE.
  - There is no bypass: the next acceptance comes at the earliest one cycle later.
- Requests are never lost. An unselected requester keeps `req_valid` high and data stable until its `req_ready`.
- Output values:
  - `rsp_data`/`rsp_id` are don't-care while `rsp_valid`=0. They are driven from internal registers.
  - `req_ready` is 0 in B2G, G2B and RESP.
  - Changing `req_valid`/`req_data` during B2G, G2B or RESP has no effect on the job in flight.
- Round-robin: the requester just served has the lowest priority at the next arbitration. With requests continuously asserted, no requester waits more than N_REQ-1 grants.

## Timing
- **Reset** (asynchronous, any state): state=IDLE, ptr=0, idx=0, result=0, id=0.
  - Outputs during and after reset: `req_ready`=0 while `rst_n`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `busy`=0.
  - A job in flight is discarded with no response.
- **Latency**, counted from the acceptance edge to the edge after which `rsp_valid` goes high:
  - Binary→Gray: 1 edge.
  - Gray→Binary: WIDTH-1 edges (3 for WIDTH=4).
- **Throughput**, with `rsp_ready` tied high: one job per 3 cycles (B2G) or per WIDTH+1 cycles (G2B).
- `busy` rises on the acceptance edge and falls on the response handshake edge.
- All `req_valid` bits rising in the same cycle are resolved purely by ptr.

## Test plan
- **B2G single request**: WIDTH=4, requester 2 sends mode=0, data 4'b1011.
  - Expect `req_ready`=4'b0100 for one cycle.
  - Expect `rsp_valid` 1 edge later with `rsp_data`=4'b1110 and `rsp_id`=2.
- **G2B single requests**, requester 0, mode=1:
  - data 4'b1110 → `rsp_data`=4'b1011 after 3 edges.
  - data 4'b1000 → `rsp_data`=4'b1111 after 3 edges.
  - Sweep all 16 codes; each G2B(B2G(x)) = x.
- **Round-robin**: all four requesters held valid, mode=0, data = k.
  - Grant order 0,1,2,3,0.
  - `rsp_data` sequence 0000, 0001, 0011, 0010.
  - A fresh request from requester 1 arriving while ptr=2 is served after requesters 2 and 3.
- **Backpressure**: hold `rsp_ready`=0 for 5 cycles in RESP.
  - `rsp_valid`, `rsp_data` and `rsp_id` stay stable.
  - `req_ready` stays 0 although requests are pending.
  - After `rsp_ready` rises, the next grant comes 1 cycle after the handshake.
- **Reset mid-operation**: assert `rst_n`=0 during the second G2B cycle.
  - Outputs go to reset values immediately; no response is issued.
  - After release, the first arbitration starts at requester 0.
